// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI program loader.
package spi_loader_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} loader_state_t;

    localparam int WORD_BITS = 32;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus one history flop; the caller derives edges from o_sync/o_prev.
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_prev
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_prev = r_prev;

endmodule

// File: rtl/spi_prog_loader.sv
// SPI slave program loader: oversampled SPI -> 32-bit LSB-first words -> instruction memory writes.
// Optional running checksum of accepted words when SPI_LOADER_CHECKSUM_EN is defined.
module spi_prog_loader
    import spi_loader_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCLK,
    input  logic                 MOSI,
    input  logic                 SS,
    input  logic                 CPOL,
    input  logic                 CPHA,
    input  logic                 PROGRAM_DONE,
    output logic                 mem_we,
    input  logic                 mem_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    output logic                 cpu_hold,
    output logic                 frame_err,
    output logic                 overrun,
    output loader_state_t        o_dbg_state
`ifdef SPI_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]          checksum
`endif
);

    logic w_sclk_sync, w_sclk_prev, w_ss_sync, w_ss_prev, w_pd_sync, w_pd_prev;

    spi_sync_edge u_sync_sclk (.clk(clk), .reset(reset), .i_async(SCLK),
                               .o_sync(w_sclk_sync), .o_prev(w_sclk_prev));
    spi_sync_edge u_sync_ss   (.clk(clk), .reset(reset), .i_async(SS),
                               .o_sync(w_ss_sync), .o_prev(w_ss_prev));
    spi_sync_edge u_sync_pd   (.clk(clk), .reset(reset), .i_async(PROGRAM_DONE),
                               .o_sync(w_pd_sync), .o_prev(w_pd_prev));

    loader_state_t          r_state, w_state_nxt;
    logic                   r_mosi_s1, r_mosi_s2;
    logic                   r_cap, w_cap_nxt;
    logic                   r_pd_pend;
    logic [5:0]             r_bit_cnt;
    logic [WORD_BITS-1:0]   r_shift;
    logic [WORD_BITS-1:0]   r_wdata;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_frame_err, r_overrun;

    logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_pd_rise;
    logic w_sample, w_active, w_shift_en, w_last, w_accept, w_done_req;
    logic w_frame_start, w_load, w_frame_err_set;
    logic [WORD_BITS-1:0] w_word;

    assign w_sclk_rise = w_sclk_sync & ~w_sclk_prev;
    assign w_sclk_fall = ~w_sclk_sync & w_sclk_prev;
    assign w_ss_rise   = w_ss_sync & ~w_ss_prev;
    assign w_ss_fall   = ~w_ss_sync & w_ss_prev;
    assign w_pd_rise   = w_pd_sync & ~w_pd_prev;

    // Modes 0 and 3 sample on rising SCLK, modes 1 and 2 on falling.
    assign w_sample   = w_ss_sync & ((CPOL == CPHA) ? w_sclk_rise : w_sclk_fall);
    assign w_active   = (r_state == SHIFT) || ((r_state == WRITE) && r_cap);
    assign w_shift_en = w_active & w_sample;
    assign w_last     = w_shift_en && (r_bit_cnt == 6'(WORD_BITS - 1));
    assign w_word     = {r_mosi_s2, r_shift[WORD_BITS-2:0]};
    assign w_accept   = (r_state == WRITE) && mem_ready;
    // A short PROGRAM_DONE pulse seen during a pending write is remembered.
    assign w_done_req = w_pd_sync | r_pd_pend;

    assign w_frame_start   = w_ss_rise && ((r_state == IDLE) || (r_state == WRITE));
    assign w_load          = w_last && (w_state_nxt == WRITE) && ((r_state == SHIFT) || w_accept);
    assign w_frame_err_set = w_ss_fall && w_active;

    always_comb begin
        w_state_nxt = r_state;
        w_cap_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_done_req)     w_state_nxt = DONE;
                else if (w_ss_rise) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_done_req)     w_state_nxt = DONE;
                else if (w_last)    w_state_nxt = WRITE;
                else if (w_ss_fall) w_state_nxt = IDLE;
            end
            WRITE: begin
                w_cap_nxt = r_cap;
                if (w_ss_rise)                  w_cap_nxt = 1'b1;
                else if (w_last || w_ss_fall)   w_cap_nxt = 1'b0;
                if (w_accept) begin
                    if (w_done_req)     w_state_nxt = DONE;
                    else if (w_last)    w_state_nxt = WRITE;
                    else if (w_cap_nxt) w_state_nxt = SHIFT;
                    else                w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mosi_s1   <= 1'b0;
            r_mosi_s2   <= 1'b0;
            r_cap       <= 1'b0;
            r_pd_pend   <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_wdata     <= '0;
            r_addr      <= START_ADDR;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
            r_cap     <= (w_state_nxt == WRITE) && w_cap_nxt;
            if (w_pd_rise)          r_pd_pend <= 1'b1;
            if (w_frame_start)      r_bit_cnt <= '0;
            else if (w_shift_en)    r_bit_cnt <= r_bit_cnt + 6'd1;
            if (w_shift_en)         r_shift[r_bit_cnt[4:0]] <= r_mosi_s2;
            if (w_load)             r_wdata <= w_word;
            if (w_accept)           r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (w_frame_err_set)    r_frame_err <= 1'b1;
            // A word finishing while the previous one is still unaccepted is dropped.
            if (w_last && (r_state == WRITE) && !w_accept) r_overrun <= 1'b1;
        end
    end

`ifdef SPI_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_checksum <= '0;
        else if (w_accept) r_checksum <= r_checksum + r_wdata;
    end

    assign checksum = r_checksum;
`endif

    assign mem_we      = (r_state == WRITE);
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign cpu_hold    = (r_state != DONE);
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_prog_loader.sv
// Directed bench for spi_prog_loader (ADDR_W=2 so address wrap is reachable quickly).
module tb_spi_prog_loader;
  import spi_loader_pkg::*;

  localparam int ADDR_W = 2;
  localparam int EXP_W  = ADDR_W + 32;
  localparam int H      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0, mosi = 1'b0, ss = 1'b0, cpol = 1'b0, cpha = 1'b0, pdone = 1'b0;
  logic mem_ready = 1'b1;
  logic mem_we, cpu_hold, frame_err, overrun;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  loader_state_t dbg_state;
`ifdef SPI_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [EXP_W-1:0] exp_q[$];

  spi_prog_loader #(.ADDR_W(ADDR_W), .START_ADDR(2'd0)) dut (
    .clk(clk), .reset(rst_n), .SCLK(sclk), .MOSI(mosi), .SS(ss),
    .CPOL(cpol), .CPHA(cpha), .PROGRAM_DONE(pdone),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .frame_err(frame_err),
    .overrun(overrun), .o_dbg_state(dbg_state)
`ifdef SPI_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_word(input logic [31:0] d, input int nbits, input logic pol,
                           input logic pha, input logic drop_ss);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    wait_clk(H);
    ss = 1'b1;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        mosi = d[i];
        wait_clk(H);
        sclk = ~pol;
        wait_clk(H);
        sclk = pol;
      end else begin
        sclk = ~pol;
        mosi = d[i];
        wait_clk(H);
        sclk = pol;
        wait_clk(H);
      end
    end
    if (drop_ss) begin
      wait_clk(H);
      ss = 1'b0;
      wait_clk(H);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_clk(1);
    check(tag, exp_q.size(), 0);
  endtask

  // scoreboard: every accepted write must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
               mem_addr, mem_wdata);
      end
      if (exp_q.size() != 0) check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  initial begin
    // reset state
    wait_clk(3);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_state", dbg_state, IDLE);
`ifdef SPI_LOADER_CHECKSUM_EN
    check("rst_csum", checksum, 0);
`endif
    rst_n = 1'b1;
    wait_clk(3);

    // mode 0, two words
    push_exp(2'd0, 32'hDEADBEEF);
    send_word(32'hDEADBEEF, 32, 1'b0, 1'b0, 1'b1);
    push_exp(2'd1, 32'h00000013);
    send_word(32'h00000013, 32, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_m0");
    check("m0_addr", mem_addr, 2);
    check("m0_wdata", mem_wdata, 32'h00000013);
    check("m0_ferr", frame_err, 0);
    check("m0_ovr", overrun, 0);

    // all four SPI modes; addresses 2,3,0,1 (5th word wraps to 0)
    for (int m = 0; m < 4; m++) begin
      push_exp(ADDR_W'(m + 2), 32'hA5A5F00F);
      send_word(32'hA5A5F00F, 32, m[1], m[0], 1'b1);
      wait_drain($sformatf("drain_mode%0d", m));
      check($sformatf("wdata_mode%0d", m), mem_wdata, 32'hA5A5F00F);
    end
    check("modes_addr", mem_addr, 2);

    // overrun: second frame completes while first write is stalled
    mem_ready = 1'b0;
    push_exp(2'd2, 32'h11111111);
    send_word(32'h11111111, 32, 1'b0, 1'b0, 1'b1);
    send_word(32'h22222222, 32, 1'b0, 1'b0, 1'b1);
    wait_clk(40);
    check("ovr_we_held", mem_we, 1);
    check("ovr_flag", overrun, 1);
    check("ovr_addr_held", mem_addr, 2);
    check("ovr_wdata_kept", mem_wdata, 32'h11111111);
    mem_ready = 1'b1;
    wait_drain("drain_ovr");
    wait_clk(2);
    check("ovr_addr_once", mem_addr, 3);
    check("ovr_state", dbg_state, IDLE);
    check("ovr_no_ferr", frame_err, 0);

    // short frame of 17 bits, then a normal frame to the same address
    send_word(32'h00012345, 17, 1'b0, 1'b0, 1'b1);
    check("ferr_flag", frame_err, 1);
    check("ferr_addr", mem_addr, 3);
    push_exp(2'd3, 32'hCAFEF00D);
    send_word(32'hCAFEF00D, 32, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_ferr");
    check("ferr_wrap_addr", mem_addr, 0);
    push_exp(2'd0, 32'h0BADC0DE);
    send_word(32'h0BADC0DE, 32, 1'b1, 1'b1, 1'b1);
    wait_drain("drain_pre_rst");
    check("pre_rst_addr", mem_addr, 1);

    // asynchronous reset in the middle of a frame (after 10 bits)
    send_word(32'hFFFFFFFF, 10, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", mem_we, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_wdata", mem_wdata, 0);
    check("arst_hold", cpu_hold, 1);
    check("arst_ferr", frame_err, 0);
    check("arst_ovr", overrun, 0);
    check("arst_state", dbg_state, IDLE);
    ss = 1'b0;
    sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);

    push_exp(2'd0, 32'h00000001);
    send_word(32'h00000001, 32, 1'b0, 1'b0, 1'b1);
    push_exp(2'd1, 32'h00000002);
    send_word(32'h00000002, 32, 1'b0, 1'b0, 1'b1);
    push_exp(2'd2, 32'hFFFFFFFF);
    send_word(32'hFFFFFFFF, 32, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_post_rst");
    check("post_rst_addr", mem_addr, 3);
`ifdef SPI_LOADER_CHECKSUM_EN
    check("csum", checksum, 32'h00000002);
`endif

    // PROGRAM_DONE: cpu_hold releases on the third clock edge
    pdone = 1'b1;
    wait_clk(2);
    check("done_hold_early", cpu_hold, 1);
    wait_clk(1);
    check("done_hold_rel", cpu_hold, 0);
    check("done_state", dbg_state, DONE);
    send_word(32'h55AA55AA, 32, 1'b0, 1'b0, 1'b1);
    send_word(32'h0000001F, 5, 1'b0, 1'b0, 1'b1);
    wait_clk(10);
    check("done_we", mem_we, 0);
    check("done_addr", mem_addr, 3);
    check("done_ferr", frame_err, 0);
    check("done_ovr", overrun, 0);
    check("done_state_kept", dbg_state, DONE);
`ifdef SPI_LOADER_CHECKSUM_EN
    check("done_csum", checksum, 32'h00000002);
`endif
    check("final_queue", exp_q.size(), 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_prog_loader.md
# spi_prog_loader

On-chip SPI slave loader that consumes the serial program stream (SCLK/MOSI/SS) produced by the SPI programming dongle. It oversamples the SPI lines in the system clock domain, assembles 32-bit words LSB-first and writes them to consecutive instruction-memory word addresses. It holds the core in reset until the dongle signals that programming is complete.

## Interface
- ADDR_W, 16, word-address width; the write address wraps modulo 2^ADDR_W.
- START_ADDR, 0, first word address written after reset.
- clk  input  1  system clock; must run at ≥4× the SCLK frequency.
- reset  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI clock from the dongle; asynchronous to clk.
- MOSI  input  1  serial data, LSB first.
- SS  input  1  frame select, active-high; one 32-bit word per high pulse.
- CPOL  input  1  clock polarity; static while SS is high.
- CPHA  input  1  clock phase; static while SS is high.
- PROGRAM_DONE  input  1  dongle end-of-image flag; asynchronous.
- mem_we  output  1  write strobe; held until accepted.
- mem_ready  input  1  memory accepts the write on a cycle where mem_we && mem_ready.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  assembled word.
- cpu_hold  output  1  keeps the core in reset while loading.
- frame_err  output  1  sticky flag: an SS frame ended with a bit count other than 32.
- overrun  output  1  sticky flag: a word completed while the previous write was still pending.

## Operation
- Synchronisation: SCLK, MOSI, SS and PROGRAM_DONE each pass through a 2-flop synchroniser. One further flop on SCLK and SS provides edge detection.
- Sample edge:
  - Rising SCLK edge when CPOL==CPHA.
  - Falling SCLK edge otherwise.
  - Only edges that occur while synchronised SS=1 count.
- On each sample edge, MOSI is shifted into bit position bit_cnt of shift_reg, and 6-bit bit_cnt increments.
- FSM states: IDLE, SHIFT, WRITE, DONE.
  - IDLE: SS rise → SHIFT, bit_cnt cleared.
  - SHIFT: when the 32nd bit is sampled, copy shift_reg to mem_wdata and → WRITE. If SS falls with bit_cnt≠32, set frame_err, discard the partial word and → IDLE.
  - WRITE: hold mem_we=1 until mem_ready. On acceptance, increment mem_addr by 1 (wraps to 0 after 2^ADDR_W−1) and → IDLE. If SS rises again during WRITE, capture the new frame into shift_reg concurrently. If that frame completes before acceptance, set overrun and drop the new word; the pending word is kept.
  - Any state except WRITE: synchronised PROGRAM_DONE=1 → DONE. In WRITE, DONE is entered only after acceptance.
  - DONE: terminal; cpu_hold=0; all SPI activity is ignored until reset.
- Reset values (mid-operation reset aborts immediately; a partial word is lost):
  - State IDLE, bit_cnt 0, shift_reg 0.
  - mem_we 0, mem_addr START_ADDR, mem_wdata 0.
  - cpu_hold 1, frame_err 0, overrun 0.

## Timing
- A bit is captured 3 clk cycles after the corresponding SCLK edge (2 synchroniser cycles plus 1 edge-detect cycle).
- mem_we rises on the clk edge after the 32nd bit is captured. mem_addr and mem_wdata are registered and stable while mem_we=1.
- mem_ready high in the first WRITE cycle gives a one-cycle write. Words separated by ≥1 SS-low clk cycle are sustained at full rate.
- cpu_hold falls 3 clk cycles after PROGRAM_DONE rises, assuming no write is pending.
- Flags are sticky until reset.

## Configuration
- SPI_LOADER_CHECKSUM_EN defined:
  - Adds output checksum[31:0], reset to 0.
  - On each accepted write, checksum ← checksum + mem_wdata, modulo 2^32.
  - Frozen in DONE.
- SPI_LOADER_CHECKSUM_EN undefined: no checksum port and no adder.

## Structure
- Shared package spi_loader_pkg:
  - typedef enum logic [1:0] loader_state_t {IDLE, SHIFT, WRITE, DONE}.
  - localparam WORD_BITS = 32.
- Sub-module spi_sync_edge: 2-flop synchroniser plus edge-detect flop, reused for SCLK, SS and PROGRAM_DONE.
- Storage flops use the existing flopr style with asynchronous active-low reset.

## Test plan
- Mode 0 (CPOL=0, CPHA=0), words 0xDEADBEEF and 0x00000013 → writes to addr 0 and 1 with those exact values; frame_err=0 and overrun=0.
- All four CPOL/CPHA combinations, word 0xA5A5F00F → mem_wdata=0xA5A5F00F in each mode.
- mem_ready held low for 40 clk while a second 32-bit frame completes → overrun=1, first word written intact, mem_addr advances by 1 only.
- SS dropped after 17 bits → frame_err=1, no mem_we; the next full frame writes normally to the same address.
- ADDR_W=2 with 5 words → the 5th word is written to addr 0. PROGRAM_DONE asserted afterwards → cpu_hold=0 within 4 clk, and later SPI activity is ignored.
- Reset asserted mid-frame (bit 10) → all outputs at reset values asynchronously, and the next frame is written to START_ADDR. With SPI_LOADER_CHECKSUM_EN, words 1, 2 and 0xFFFFFFFF → checksum=0x00000002.
